// File: rtl/shift_pkg.sv
// shift_engine shared definitions: mode encodings and FSM states.
// No ports; imported by shift_step and shift_engine.
package shift_pkg;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_LSL = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_ASR = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

endpackage

// File: rtl/shift_engine_if.sv
// Handshake/data bundle between a parallel-load master and shift_engine.
// master drives load/data/start/mode/amt/sin/ena; slave drives q/sout/busy/done.
interface shift_engine_if #(
    parameter int size  = 8,
    parameter int AMT_W = $clog2(size) + 1
);
    logic             load;
    logic [size-1:0]  data;
    logic             start;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amt;
    logic             sin;
    logic             ena;
    logic [size-1:0]  q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output load, data, start, mode, amt, sin, ena,
        input  q, sout, busy, done
    );

    modport slave (
        input  load, data, start, mode, amt, sin, ena,
        output q, sout, busy, done
    );
endinterface

// File: rtl/shift_step.sv
// Combinational single-bit shift step: word/mode/sin -> next word + out bit.
// Macro SHIFT_ENGINE_ROTATE_EN enables rotate-right for MODE_ROR.
module shift_step
    import shift_pkg::*;
#(
    parameter int size = 8
) (
    input  logic [size-1:0] word,
    input  logic [1:0]      mode,
    input  logic            sin,
    output logic [size-1:0] next,
    output logic            out
);

    always_comb begin
        next = word;
        out  = 1'b0;
        unique case (mode)
            MODE_LSR: begin
                next = {sin, word[size-1:1]};
                out  = word[0];
            end
            MODE_LSL: begin
                next = {word[size-2:0], sin};
                out  = word[size-1];
            end
            MODE_ROR: begin
`ifdef SHIFT_ENGINE_ROTATE_EN
                next = {word[0], word[size-1:1]};
`else
                // Without rotate support this mode is a plain logical right.
                next = {sin, word[size-1:1]};
`endif
                out  = word[0];
            end
            MODE_ASR: begin
                next = {word[size-1], word[size-1:1]};
                out  = word[0];
            end
            default: begin
                next = word;
                out  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// Multi-mode shift register: parallel load, N single-bit shifts, done pulse.
// Ports: clk, areset (sync, active-high), bus (shift_engine_if.slave).
// Optional macro SHIFT_ENGINE_ROTATE_EN enables rotate-right in mode 2'b10.
module shift_engine
    import shift_pkg::*;
#(
    parameter int size  = 8,
    parameter int AMT_W = $clog2(size) + 1
) (
    input  logic           clk,
    input  logic           areset,
    shift_engine_if.slave  bus
);

    localparam int CNT_W = $clog2(size + 1);

    state_e           state_q, state_d;
    logic [size-1:0]  word_q, word_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] amt_sat;
    logic [size-1:0]  step_word;
    logic             step_out;

    shift_step #(
        .size (size)
    ) u_step (
        .word (word_q),
        .mode (mode_q),
        .sin  (bus.sin),
        .next (step_word),
        .out  (step_out)
    );

    // Shifting more than the word width is equivalent to shifting by it.
    always_comb begin
        if (int'(bus.amt) > size) begin
            amt_sat = CNT_W'(size);
        end else begin
            amt_sat = CNT_W'(bus.amt);
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sout_d  = sout_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    word_d = bus.data;
                end else if (bus.start) begin
                    if (amt_sat == '0) begin
                        done_d = 1'b1;
                    end else begin
                        mode_d  = bus.mode;
                        cnt_d   = amt_sat;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (bus.load) begin
                    // Abort: reload and drop the sequence silently.
                    word_d  = bus.data;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (bus.ena) begin
                    word_d = step_word;
                    sout_d = step_out;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= MODE_LSR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.q    = word_q;
    assign bus.sout = sout_q;
    assign bus.busy = (state_q == ST_SHIFT);
    assign bus.done = done_q;

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine (size=8): directed plan + random run.
// Reference model works on integer words and a remaining-shift count.
module tb_shift_engine;

    logic clk = 1'b0;
    logic areset;

    always #5 clk = ~clk;

    shift_engine_if #(.size(8)) bus ();

    shift_engine #(.size(8)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_q;
    int m_sout;
    int m_busy;
    int m_done;
    int m_rem;
    int m_mode;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One shift step on an 8-bit integer word.
    task automatic ref_step(input int mode, input int sin,
                            inout int w, output int out);
        case (mode)
            0: begin
                out = w % 2;
                w   = (w / 2) + (sin ? 128 : 0);
            end
            1: begin
                out = (w / 128) % 2;
                w   = ((w * 2) % 256) + sin;
            end
            2: begin
                out = w % 2;
`ifdef SHIFT_ENGINE_ROTATE_EN
                w   = (w / 2) + (out * 128);
`else
                w   = (w / 2) + (sin ? 128 : 0);
`endif
            end
            default: begin
                out = w % 2;
                w   = (w / 2) + ((w >= 128) ? 128 : 0);
            end
        endcase
    endtask

    task automatic model_update(input int rst, input int ld, input int dat,
                                input int st, input int md, input int am,
                                input int si, input int en);
        int nd;
        int o;
        nd = 0;
        if (rst != 0) begin
            m_q = 0; m_sout = 0; m_busy = 0;
            m_rem = 0; m_mode = 0;
        end else if (m_busy == 0) begin
            if (ld != 0) begin
                m_q = dat;
            end else if (st != 0) begin
                if (am == 0) begin
                    nd = 1;
                end else begin
                    m_mode = md;
                    m_rem  = (am > 8) ? 8 : am;
                    m_busy = 1;
                end
            end
        end else if (ld != 0) begin
            m_q = dat;
            m_busy = 0;
            m_rem = 0;
        end else if (en != 0) begin
            ref_step(m_mode, si, m_q, o);
            m_sout = o;
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0;
                nd = 1;
            end
        end
        m_done = nd;
    endtask

    // Advance one clock with the current inputs, then compare everything.
    task automatic tick(input string tag);
        int rst, ld, dat, st, md, am, si, en;
        rst = int'(areset);
        ld  = int'(bus.load);
        dat = int'(bus.data);
        st  = int'(bus.start);
        md  = int'(bus.mode);
        am  = int'(bus.amt);
        si  = int'(bus.sin);
        en  = int'(bus.ena);
        @(posedge clk);
        #1;
        model_update(rst, ld, dat, st, md, am, si, en);
        chk({tag, ".q"},    int'(bus.q),    m_q);
        chk({tag, ".sout"}, int'(bus.sout), m_sout);
        chk({tag, ".busy"}, int'(bus.busy), m_busy);
        chk({tag, ".done"}, int'(bus.done), m_done);
    endtask

    task automatic idle_inputs();
        areset = 1'b0;
        bus.load = 1'b0; bus.data = '0; bus.start = 1'b0;
        bus.mode = '0; bus.amt = '0; bus.sin = 1'b0; bus.ena = 1'b1;
    endtask

    task automatic do_load(input logic [7:0] d, input string tag);
        bus.load = 1'b1; bus.data = d;
        tick(tag);
        bus.load = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] md, input logic [3:0] am,
                            input string tag);
        bus.start = 1'b1; bus.mode = md; bus.amt = am;
        tick(tag);
        bus.start = 1'b0;
    endtask

    initial begin
        m_q = 0; m_sout = 0; m_busy = 0; m_done = 0; m_rem = 0; m_mode = 0;
        idle_inputs();

        // Reset
        areset = 1'b1;
        tick("rst0");
        tick("rst1");
        areset = 1'b0;
        chk("rst_q", int'(bus.q), 0);

        // Logical right
        do_load(8'hA5, "lsr_ld");
        do_start(2'b00, 4'd3, "lsr_st");
        tick("lsr1"); chk("lsr1_val", int'(bus.q), 'h52);
        tick("lsr2"); chk("lsr2_val", int'(bus.q), 'h29);
        tick("lsr3"); chk("lsr3_val", int'(bus.q), 'h14);
        chk("lsr_sout", int'(bus.sout), 1);
        chk("lsr_done", int'(bus.done), 1);
        tick("lsr4"); chk("lsr_done_low", int'(bus.done), 0);

        // Arithmetic right
        do_load(8'h96, "asr_ld");
        do_start(2'b11, 4'd2, "asr_st");
        tick("asr1");
        tick("asr2"); chk("asr_val", int'(bus.q), 'hE5);
        tick("asr3");

        // Rotate (or logical right when rotate is disabled)
        do_load(8'h81, "ror_ld");
        bus.sin = 1'b0;
        do_start(2'b10, 4'd1, "ror_st");
        tick("ror1");
`ifdef SHIFT_ENGINE_ROTATE_EN
        chk("ror_val", int'(bus.q), 'hC0);
`else
        chk("ror_val", int'(bus.q), 'h40);
`endif
        chk("ror_sout", int'(bus.sout), 1);
        tick("ror2");

        // Stall during a logical left
        do_load(8'h01, "stl_ld");
        do_start(2'b01, 4'd4, "stl_st");
        tick("stl1");
        tick("stl2");
        bus.ena = 1'b0;
        tick("stl3"); chk("stl_hold3", int'(bus.q), 'h04);
        tick("stl4"); chk("stl_hold4", int'(bus.q), 'h04);
        bus.ena = 1'b1;
        tick("stl5"); chk("stl5_done", int'(bus.done), 0);
        tick("stl6"); chk("stl_val", int'(bus.q), 'h10);
        chk("stl6_done", int'(bus.done), 1);
        tick("stl7");

        // Reset in the middle of a sequence
        do_load(8'h5A, "mrst_ld");
        do_start(2'b00, 4'd5, "mrst_st");
        tick("mrst1");
        areset = 1'b1;
        tick("mrst2");
        chk("mrst_q", int'(bus.q), 0);
        chk("mrst_busy", int'(bus.busy), 0);
        tick("mrst3");
        areset = 1'b0;
        for (int i = 0; i < 6; i++) tick("mrst_post");
        chk("mrst_no_resume", int'(bus.busy), 0);

        // Load aborts a busy sequence
        do_load(8'hF0, "ab_ld");
        do_start(2'b00, 4'd4, "ab_st");
        tick("ab1");
        do_load(8'h3C, "ab_reload");
        chk("ab_val", int'(bus.q), 'h3C);
        chk("ab_busy", int'(bus.busy), 0);
        tick("ab2"); chk("ab_no_done", int'(bus.done), 0);

        // amt = 0
        do_start(2'b01, 4'd0, "z_st");
        chk("z_done", int'(bus.done), 1);
        chk("z_q", int'(bus.q), 'h3C);
        tick("z1");

        // amt saturates at the word width
        do_load(8'hFF, "sat_ld");
        bus.sin = 1'b0;
        do_start(2'b01, 4'd12, "sat_st");
        for (int i = 0; i < 7; i++) tick("sat_run");
        chk("sat_not_done", int'(bus.done), 0);
        tick("sat8");
        chk("sat_val", int'(bus.q), 0);
        chk("sat_done", int'(bus.done), 1);
        tick("sat9");

        // Random run against the model
        for (int i = 0; i < 600; i++) begin
            areset    = ($urandom_range(0, 99) < 2);
            bus.load  = ($urandom_range(0, 99) < 8);
            bus.data  = 8'($urandom);
            bus.start = ($urandom_range(0, 99) < 40);
            bus.mode  = 2'($urandom);
            bus.amt   = 4'($urandom_range(0, 12));
            bus.sin   = 1'($urandom);
            bus.ena   = ($urandom_range(0, 99) < 75);
            tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
# shift_engine

- Parametrised, multi-mode successor to the 4-bit load/enable shift register.
- Holds a `size`-bit word, loaded in parallel, and runs a programmed number of single-bit shifts, one per enabled clock.
- Supports logical left/right, arithmetic right and (optionally) rotate right, with serial in/out.
- Signals completion with a busy/done handshake. Sits between a parallel-load datapath and serial consumers.

## Interface
- `size`, default 8: word width in bits, ≥ 2.
- `AMT_W`, default `$clog2(size)+1`: width of the shift-amount input.
- `clk`  input  1: sole clock; all state updates on the rising edge.
- `areset`  input  1: reset, synchronous and active-high, sampled on the `clk` rising edge.
- `load`  input  1: parallel load of `data` into `q`.
- `data`  input  `size`: parallel load value.
- `start`  input  1: begin a shift sequence.
- `mode`  input  2: shift mode, sampled at `start`.
- `amt`  input  `AMT_W`: number of single-bit shifts, sampled at `start`.
- `sin`  input  1: serial input for the logical modes, sampled on every shift edge.
- `ena`  input  1: shift advance enable; 0 stalls the sequence.
- `q`  output  `size`: register contents.
- `sout`  output  1: last bit shifted out.
- `busy`  output  1: sequence in progress.
- `done`  output  1: one-cycle completion pulse.

## Operation
- Reset values: `q`=0, `sout`=0, `busy`=0, `done`=0; internal count=0; state=IDLE.
- States:
  - IDLE: no sequence running.
  - SHIFT: sequence running; `busy` = (state==SHIFT).
- In IDLE:
  - `load`=1: `q` ← `data`. `load` has priority over `start`; a simultaneous `start` is dropped.
  - `start`=1, `load`=0, `amt`>0: latch `mode` and min(`amt`, `size`), then go to SHIFT.
  - `start`=1, `load`=0, `amt`=0: stay in IDLE; `done` pulses next cycle; `q` unchanged.
- In SHIFT, on each edge with `ena`=1:
  - Perform one step; `sout` ← the bit shifted out; count decrements.
  - On the step that takes count from 1 to 0, return to IDLE and set `done`=1 for exactly one cycle.
  - `ena`=0: `q`, `sout` and count hold.
- Mode encoding:
  - 00: logical right, MSB ← `sin`.
  - 01: logical left, LSB ← `sin`.
  - 10: rotate right (see Configuration).
  - 11: arithmetic right, MSB replicated, `sin` ignored.
- `load`=1 while busy aborts the sequence: `q` ← `data`, return to IDLE, no `done` pulse.
- `start` while busy is ignored.
- `areset` mid-sequence returns every output to its reset value on that edge.
- `amt` > `size` saturates to `size`. A logical shift by `size` fully replaces `q` with `sin` bits; a rotate by `size` restores the original word.
- `sout` holds between sequences; `load` does not change it.

## Timing
- Start accepted at edge 0 with `amt`=N and `ena` held at 1:
  - `busy`=1 after edge 0.
  - Shifts occur at edges 1..N.
  - After edge N: `busy`=0, `done`=1, `q` final.
  - After edge N+1: `done`=0.
- Each stalled cycle (`ena`=0) adds exactly one cycle to this timeline.
- `amt`=0: `done`=1 after edge 0.
- Load latency: `q` updates one edge after `load`.
- A new `start` may be accepted in the same cycle `done` is high.

## Configuration
- `SHIFT_ENGINE_ROTATE_EN` defined: mode 10 rotates right, MSB ← outgoing LSB, `sin` ignored.
- Undefined: mode 10 behaves exactly as mode 00 (logical right), and no rotate logic is synthesised.

## Structure
- Package `shift_pkg` holds:
  - The mode encodings: `MODE_LSR`=2'b00, `MODE_LSL`=2'b01, `MODE_ROR`=2'b10, `MODE_ASR`=2'b11.
  - The state enum `{ST_IDLE, ST_SHIFT}`.
- Sub-module `shift_step`: purely combinational single-bit step. Inputs are word, `mode` and `sin`; outputs are the next word and the out bit. It is instantiated once inside `shift_engine`, which owns the FSM, counter and registers.

## Test plan
All scenarios use `size`=8.
- Reset: assert `areset` for 2 cycles mid-sequence → `q`=8'h00, `busy`=0, `done`=0, `sout`=0 on the next edge; the sequence does not resume.
- Logical right: load 8'hA5; start `mode`=00, `amt`=3, `sin`=0, `ena`=1 → `q` steps 8'h52, 8'h29, 8'h14; `sout`=1; `done` high exactly one cycle, 3 edges after start.
- Arithmetic right: load 8'h96; start `mode`=11, `amt`=2 → `q`=8'hE5.
- Rotate: load 8'h81; start `mode`=10, `amt`=1, `sin`=0.
  - With `SHIFT_ENGINE_ROTATE_EN`: `q`=8'hC0, `sout`=1.
  - Without: `q`=8'h40.
- Stall: load 8'h01; start `mode`=01, `amt`=4; drop `ena` for 2 cycles mid-sequence → `q`=8'h10; `done` arrives 6 edges after start; `q` holds during the stall.
- Edge cases:
  - `load` 8'h3C during busy → `q`=8'h3C, `busy`=0, no `done`.
  - `amt`=0 → `done` next cycle, `q` unchanged.
  - `amt`=12 with `mode`=01 on 8'hFF, `sin`=0 → 8 shifts, `q`=8'h00.
